// File: rtl/mul_rr_sched.sv
// rtl/mul_rr_sched.sv - round-robin scheduler sharing one pipelined FP32 multiplier among NUM_REQ requesters
// Optional MUL_RR_SCHED_STATS_EN adds stat_issued/stat_stall counters.
module mul_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sched_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [63:0]          mul_in,
  output logic                 mul_stb,
  input  logic [31:0]          mul_z,
  input  logic                 mul_z_stb,
  output logic [NUM_REQ-1:0]   res_valid,
  output logic [31:0]          res_z,
  output logic                 busy,
  output logic                 err_sync
`ifdef MUL_RR_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int HOLD_W = $clog2(MUL_LAT + 2);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MUL_LAT + 1);

  state_t            state, state_nx;
  logic [ID_W-1:0]   rr_ptr, gnt_id, cand;
  logic              gnt, pending;
  logic [31:0]       sel_a, sel_b;
  logic [HOLD_W-1:0] holdoff;

  // Stage 0 is loaded alongside mul_stb; stage MUL_LAT lines up with mul_z_stb.
  logic [MUL_LAT:0]  tag_v;
  logic [ID_W-1:0]   tag_id [MUL_LAT+1];

  // Reverse scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    cand   = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt    = 1'b1;
        gnt_id = cand;
      end
    end
    if (state != RUN) gnt = 1'b0;
    req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        sel_a = req_a[32*k +: 32];
        sel_b = req_b[32*k +: 32];
      end
    end
  end

  assign pending = gnt | (|tag_v[MUL_LAT-1:0]);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sched_en) state_nx = RUN;
      RUN:     if (!sched_en) state_nx = pending ? DRAIN : IDLE;
      DRAIN:   if (sched_en) state_nx = RUN;
               else if (!pending) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[MUL_LAT-1:0], gnt};
      tag_id[0] <= gnt_id;
      for (int k = 1; k <= MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      mul_in    <= '0;
      mul_stb   <= 1'b0;
      res_valid <= '0;
      res_z     <= '0;
      busy      <= 1'b0;
      err_sync  <= 1'b0;
      holdoff   <= HOLD_INIT;
    end else begin
      state   <= state_nx;
      busy    <= (state != IDLE) | (|tag_v);
      mul_stb <= gnt;
      if (gnt) begin
        mul_in <= {sel_a, sel_b};
        rr_ptr <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
      end
      res_valid <= '0;
      if (tag_v[MUL_LAT] && mul_z_stb) begin
        res_valid <= NUM_REQ'(1) << tag_id[MUL_LAT];
        res_z     <= mul_z;
      end
      // Strobes from operations issued before reset may still be emerging.
      if (holdoff != '0) holdoff <= holdoff - HOLD_W'(1);
      else if (tag_v[MUL_LAT] != mul_z_stb) err_sync <= 1'b1;
    end
  end

`ifdef MUL_RR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (gnt) stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !gnt && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_rr_sched.sv
// tb/tb_mul_rr_sched.sv - randomized self-checking bench for mul_rr_sched with a queue-based model
module tb_mul_rr_sched;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sched_en = 1'b0;
  logic inj = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0] req_ready, res_valid;
  logic [63:0] mul_in;
  logic mul_stb, mul_z_stb, busy, err_sync;
  logic [31:0] mul_z, res_z;
`ifdef MUL_RR_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stall;
  logic [31:0] e_iss = '0, e_stall = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_rr_sched #(.NUM_REQ(N), .ID_W(IDW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_in(mul_in), .mul_stb(mul_stb), .mul_z(mul_z), .mul_z_stb(mul_z_stb),
    .res_valid(res_valid), .res_z(res_z), .busy(busy), .err_sync(err_sync)
`ifdef MUL_RR_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Truncating FP32 multiply for normal operands.
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [8:0]  e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 9'(a[30:23]) + 9'(b[30:23]) - 9'd127;
    if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  // Stand-in multiplier: fixed LAT-cycle pipe, not reset by the scheduler.
  logic [LAT-1:0] mp_stb = '0;
  logic [31:0] mp_z [LAT] = '{default: '0};
  assign mul_z_stb = mp_stb[LAT-1] | inj;
  assign mul_z = mp_z[LAT-1];
  always @(posedge clk) begin
    mp_stb <= {mp_stb[LAT-2:0], mul_stb};
    mp_z[0] <= fpmul(mul_in[63:32], mul_in[31:0]);
    for (int k = 1; k < LAT; k++) mp_z[k] <= mp_z[k-1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    longint      h;
  } op_t;

  op_t ops[$];
  int glog[$];
  int rcnt = 0;
  int m_state = 0;
  int m_ptr = 0;
  longint cyc = 0;
  longint rel = 0;
  logic e_stb = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [63:0] e_in = '0;
  logic [N-1:0] e_rv = '0;
  logic [31:0] e_rz = '0;

  // Model: ops is the set of issued operations keyed by h, the first cycle mul_stb shows them.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    logic out, busy_n;
    if (!rst_n) begin
      ops.delete();
      m_state = 0; m_ptr = 0;
      e_stb = 0; e_in = '0; e_rv = '0; e_rz = '0; e_busy = 0; e_err = 0;
`ifdef MUL_RR_SCHED_STATS_EN
      e_iss = '0; e_stall = '0;
`endif
      rel = cyc + 1;
    end
    g = -1;
    if (rst_n && m_state == 1)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;

    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("mul_stb", 64'(mul_stb), 64'(e_stb));
    chk("mul_in", mul_in, e_in);
    chk("res_valid", 64'(res_valid), 64'(e_rv));
    chk("res_z", 64'(res_z), 64'(e_rz));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("err_sync", 64'(err_sync), 64'(e_err));
`ifdef MUL_RR_SCHED_STATS_EN
    chk("stat_issued", 64'(stat_issued), 64'(e_iss));
    chk("stat_stall", 64'(stat_stall), 64'(e_stall));
`endif
    if (res_valid != '0) rcnt++;
    for (int k = 0; k < N; k++) if (req_ready[k] && req_valid[k]) glog.push_back(k);

    if (rst_n) begin
      busy_n = (m_state != 0) || (ops.size() != 0);
      out = (ops.size() != 0) && (ops[0].h + LAT == cyc);
      if ((cyc - rel) > LAT && (mul_z_stb != out)) e_err = 1'b1;
      if (out && mul_z_stb) begin
        e_rv = N'(1) << ops[0].id;
        e_rz = fpmul(ops[0].a, ops[0].b);
      end else begin
        e_rv = '0;
      end
      if (out) void'(ops.pop_front());
      e_busy = busy_n;
      if (g >= 0) begin
        ops.push_back('{g, req_a[32*g +: 32], req_b[32*g +: 32], cyc + 1});
        e_stb = 1'b1;
        e_in = {req_a[32*g +: 32], req_b[32*g +: 32]};
        m_ptr = (g + 1) % N;
      end else begin
        e_stb = 1'b0;
      end
`ifdef MUL_RR_SCHED_STATS_EN
      if (g >= 0) e_iss = e_iss + 32'd1;
      if ((req_valid != '0) && g < 0 && e_stall != '1) e_stall = e_stall + 32'd1;
`endif
      case (m_state)
        0: if (sched_en) m_state = 1;
        1: if (!sched_en) m_state = (ops.size() != 0) ? 2 : 0;
        default: if (sched_en) m_state = 1;
                 else if (ops.size() == 0) m_state = 0;
      endcase
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic rnd_ops();
    for (int k = 0; k < N; k++) begin
      req_a[32*k +: 32] = rnd_fp();
      req_b[32*k +: 32] = rnd_fp();
    end
  endtask

  initial begin
    int k;
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_mul_in", mul_in, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    tick();

    sched_en = 1'b1;
    tick();
    req_valid = 4'b0001;
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4040_0000;
    tick();
    req_valid = '0;
    chk("single_mul_in", mul_in, 64'h4000_0000_4040_0000);
    chk("single_mul_stb", 64'(mul_stb), 64'h1);
    k = 0;
    while (res_valid == '0 && k < 12) begin tick(); k++; end
    chk("single_latency", 64'(k), 64'(LAT + 1));
    chk("single_res_valid", 64'(res_valid), 64'h1);
    chk("single_res_z", 64'(res_z), 64'h40C0_0000);

    do_reset();
    glog.delete();
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b1111;
      rnd_ops();
      tick();
    end
    req_valid = '0;
    chk("rr_count", 64'(glog.size()), 64'd8);
    for (int c = 0; c < 8 && c < glog.size(); c++) chk("rr_order", 64'(glog[c]), 64'(c % 4));
    repeat (LAT + 3) tick();

    do_reset();
    glog.delete();
    rnd_ops();
    req_valid = 4'b1010;
    repeat (3) tick();
    req_valid = '0;
    chk("sparse_count", 64'(glog.size()), 64'd3);
    if (glog.size() == 3) begin
      chk("sparse_g0", 64'(glog[0]), 64'd1);
      chk("sparse_g1", 64'(glog[1]), 64'd3);
      chk("sparse_g2", 64'(glog[2]), 64'd1);
    end
    repeat (LAT + 3) tick();

    glog.delete();
    rcnt = 0;
    rnd_ops();
    req_valid = 4'b1111;
    tick(); tick();
    sched_en = 1'b0;
    tick();
    k = 0;
    while (busy && k < 30) begin tick(); k++; end
    chk("drain_busy_fell", 64'(busy), 64'h0);
    chk("drain_grants", 64'(glog.size()), 64'd3);
    chk("drain_results", 64'(rcnt), 64'd3);
    req_valid = '0;
    tick();

    for (int c = 0; c < 400; c++) begin
      sched_en = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom);
      rnd_ops();
      tick();
    end
    sched_en = 1'b1;
    req_valid = '0;
    repeat (LAT + 4) tick();

    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick();
    chk("inject_err", 64'(err_sync), 64'h1);
    chk("inject_res_valid", 64'(res_valid), 64'h0);
    repeat (3) tick();
    chk("inject_sticky", 64'(err_sync), 64'h1);

    rnd_ops();
    req_valid = 4'b1111;
    tick(); tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    chk("midrst_mul_in", mul_in, 64'h0);
    chk("midrst_mul_stb", 64'(mul_stb), 64'h0);
    chk("midrst_res_valid", 64'(res_valid), 64'h0);
    chk("midrst_res_z", 64'(res_z), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_err", 64'(err_sync), 64'h0);
    tick();
    rst_n = 1'b1;
    rcnt = 0;
    repeat (8) tick();
    chk("midrst_no_results", 64'(rcnt), 64'h0);
    chk("midrst_err_clear", 64'(err_sync), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
